uart_frame_scheduler: RTL
=========================

// Module: uart_frame_scheduler
// PURPOSE
//  Sequences a stored frame out over the 2-byte pixel UART transmitter (uart_tx_2_bytes).
//  On a start request it walks the frame buffer in row-major order, reads one 12-bit pixel
//  per step, and hands each pixel to the UART under a send/ready handshake.
//  It sits between the frame-buffer read port and the UART TX.
//  It pulses done at end of frame and supports abort and pixel subsampling.
// PARAMETERS
//  IMG_W      320     frame width in pixels
//  IMG_H      240     frame height in pixels
//  ADDR_W     17      frame-buffer address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H
//  STEP       1       subsample stride on both axes (1 = every pixel); send pixels where x%STEP==0 and y%STEP==0
//  ACK_TMO    1023    max cycles to wait for tx_ready to fall after a send pulse
// PORTS
//  clk         in   1       system clock
//  reset       in   1       synchronous, active-high
//  start       in   1       1-cycle pulse: begin a frame; ignored while busy
//  abort       in   1       1-cycle pulse: stop the frame after the pixel in flight
//  fb_addr     out  ADDR_W  frame-buffer read address
//  fb_rd       out  1       frame-buffer read strobe
//  fb_data     in   12      read data, valid exactly 1 cycle after fb_rd
//  tx_pixel    out  12      pixel presented to the UART; held stable from SEND until WAIT_READY exits
//  tx_send     out  1       1-cycle send pulse to the UART
//  tx_ready    in   1       UART ready: high = idle, falls after accepting a send
//  busy        out  1       high from start acceptance until return to IDLE
//  done        out  1       1-cycle pulse when the last pixel completes, or on abort/timeout
//  err_tmo     out  1       sticky ack-timeout flag; cleared by reset or by the next accepted start
//  pix_count   out  ADDR_W  pixels sent in the current/last frame
// BEHAVIOUR
//  Reset: state IDLE; fb_addr=0, fb_rd=0, tx_pixel=0, tx_send=0, busy=0, done=0, err_tmo=0, pix_count=0.
//  States:
//   IDLE       start=1 -> FETCH; clears x/y/row_base/pix_count/err_tmo; busy=1.
//   FETCH      fb_addr=row_base+x, fb_rd=1 for 1 cycle -> LATCH.
//   LATCH      tx_pixel<=fb_data -> SEND_WAIT.
//   SEND_WAIT  waits for tx_ready=1; then tx_send=1 for 1 cycle -> WAIT_ACK.
//   WAIT_ACK   waits for tx_ready=0.
//              If the fall is not seen within ACK_TMO cycles: err_tmo=1, done pulse -> IDLE.
//   WAIT_READY waits for tx_ready=1; pix_count++ -> ADVANCE.
//   ADVANCE    x+=STEP; if x>=IMG_W: x=0, y+=STEP, row_base+=STEP*IMG_W.
//              If y>=IMG_H: done=1 -> IDLE; else -> FETCH.
//  Address generation: no multiplier; row_base is an accumulator.
//   Max address IMG_W*IMG_H-1, never exceeded; counters have no wrap.
//  Latency: start to first tx_send = 3 cycles when tx_ready is already high.
//  Abort: latched when it arrives.
//   In FETCH/LATCH/SEND_WAIT: -> IDLE next cycle, no send, done pulse.
//   In WAIT_ACK/WAIT_READY: the current pixel finishes, then done pulse -> IDLE.
//  start during busy is ignored. start and abort in the same IDLE cycle: start wins, abort dropped.
//  Reset mid-frame returns to reset values immediately; tx_send never asserts during reset.
//  Frame length = ceil(IMG_W/STEP) * ceil(IMG_H/STEP) pixels.
// TESTING
//  Use IMG_W=4, IMG_H=2, STEP=1 with a UART model (ready falls 1 cycle after send, high 20 cycles later).
//  1 Full frame: fb holds addr*0x111 truncated to 12 bits; start.
//    -> 8 sends in address order 0..7, tx_pixel matches; done pulse once; pix_count=8; busy low after done.
//  2 STEP=2: start -> sends addresses 0,2 only; pix_count=2; done.
//  3 Abort after the 3rd send, during WAIT_READY -> the 3rd pixel completes, no 4th send; done; pix_count=3.
//  4 UART model never drops ready (ACK_TMO=15) -> err_tmo=1 after 15 cycles in WAIT_ACK;
//    done pulse; next start clears err_tmo.
//  5 start pulsed repeatedly while busy -> ignored; exactly 8 sends.
//    Reset asserted mid-frame -> all outputs return to 0 the next cycle.
//  6 tx_ready held low for 50 cycles at start -> no tx_send until ready rises;
//    first send 1 cycle after the rise.

Source files
------------

// File: rtl/uart_frame_scheduler.sv
// Frame scheduler: walks a frame buffer in row-major order (with optional subsampling)
// and hands each 12-bit pixel to a 2-byte UART transmitter under a send/ready handshake.
module uart_frame_scheduler #(
  parameter int IMG_W   = 320,
  parameter int IMG_H   = 240,
  parameter int ADDR_W  = 17,
  parameter int STEP    = 1,
  parameter int ACK_TMO = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_rd,
  input  logic [11:0]       fb_data,
  output logic [11:0]       tx_pixel,
  output logic              tx_send,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              err_tmo,
  output logic [ADDR_W-1:0] pix_count
);

  localparam int XW = $clog2(IMG_W + STEP + 1);
  localparam int YW = $clog2(IMG_H + STEP + 1);
  localparam int TW = $clog2(ACK_TMO + 1);
  localparam logic [XW-1:0]     X_STEP   = XW'(STEP);
  localparam logic [XW-1:0]     X_LIM    = XW'(IMG_W);
  localparam logic [YW-1:0]     Y_STEP   = YW'(STEP);
  localparam logic [YW-1:0]     Y_LIM    = YW'(IMG_H);
  // Only added while another row exists, so the product always fits ADDR_W.
  localparam logic [ADDR_W-1:0] ROW_INC  = ADDR_W'(STEP * IMG_W);
  localparam logic [TW-1:0]     TMO_LAST = TW'(ACK_TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH      = 3'd1,
    S_LATCH      = 3'd2,
    S_SEND_WAIT  = 3'd3,
    S_WAIT_ACK   = 3'd4,
    S_WAIT_READY = 3'd5,
    S_ADVANCE    = 3'd6
  } state_t;

  state_t            state_r, state_n;
  logic [XW-1:0]     x_r, x_n, x_sum_s;
  logic [YW-1:0]     y_r, y_n, y_sum_s;
  logic [ADDR_W-1:0] row_r, row_n;
  logic [TW-1:0]     tmo_r, tmo_n;
  logic              abort_pend_r, abort_pend_n, abort_s;
  logic [ADDR_W-1:0] fb_addr_r, addr_n;
  logic              fb_rd_r;
  logic [11:0]       tx_pixel_r, pixel_n;
  logic              tx_send_r;
  logic              busy_r;
  logic              done_r, done_n;
  logic              err_tmo_r, err_n;
  logic [ADDR_W-1:0] pix_r, pix_n;

  // Next-state and datapath update for the frame walk.
  always_comb begin
    state_n      = state_r;
    x_n          = x_r;
    y_n          = y_r;
    row_n        = row_r;
    tmo_n        = tmo_r;
    pix_n        = pix_r;
    err_n        = err_tmo_r;
    done_n       = 1'b0;
    pixel_n      = tx_pixel_r;
    x_sum_s      = x_r + X_STEP;
    y_sum_s      = y_r + Y_STEP;
    abort_s      = abort | abort_pend_r;
    abort_pend_n = abort_pend_r | (abort && (state_r != S_IDLE));

    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_n = S_FETCH;
          x_n     = {XW{1'b0}};
          y_n     = {YW{1'b0}};
          row_n   = {ADDR_W{1'b0}};
          pix_n   = {ADDR_W{1'b0}};
          err_n   = 1'b0;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_FETCH: begin
        if (abort_s) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else begin
          state_n = S_LATCH;
        end
      end
      S_LATCH: begin
        pixel_n = fb_data;
        // Skip SEND_WAIT when the UART is already idle to keep start-to-send at 3 cycles.
        if (abort_s) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else if (tx_ready) begin
          state_n = S_WAIT_ACK;
          tmo_n   = {TW{1'b0}};
        end else begin
          state_n = S_SEND_WAIT;
        end
      end
      S_SEND_WAIT: begin
        if (abort_s) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else if (tx_ready) begin
          state_n = S_WAIT_ACK;
          tmo_n   = {TW{1'b0}};
        end else begin
          state_n = S_SEND_WAIT;
        end
      end
      S_WAIT_ACK: begin
        if (!tx_ready) begin
          state_n = S_WAIT_READY;
        end else if (tmo_r == TMO_LAST) begin
          state_n = S_IDLE;
          err_n   = 1'b1;
          done_n  = 1'b1;
        end else begin
          tmo_n = tmo_r + TW'(1);
        end
      end
      S_WAIT_READY: begin
        if (tx_ready) begin
          pix_n = pix_r + ADDR_W'(1);
          if (abort_s) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = S_ADVANCE;
          end
        end else begin
          state_n = S_WAIT_READY;
        end
      end
      S_ADVANCE: begin
        if (abort_s) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else if (x_sum_s >= X_LIM) begin
          if (y_sum_s >= Y_LIM) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = S_FETCH;
            x_n     = {XW{1'b0}};
            y_n     = y_sum_s;
            row_n   = row_r + ROW_INC;
          end
        end else begin
          state_n = S_FETCH;
          x_n     = x_sum_s;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (state_n == S_IDLE) begin
      abort_pend_n = 1'b0;
    end else begin
      abort_pend_n = abort_pend_n;
    end
    addr_n = row_n + ADDR_W'(x_n);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      x_r          <= {XW{1'b0}};
      y_r          <= {YW{1'b0}};
      row_r        <= {ADDR_W{1'b0}};
      tmo_r        <= {TW{1'b0}};
      abort_pend_r <= 1'b0;
      fb_addr_r    <= {ADDR_W{1'b0}};
      fb_rd_r      <= 1'b0;
      tx_pixel_r   <= 12'h000;
      tx_send_r    <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_tmo_r    <= 1'b0;
      pix_r        <= {ADDR_W{1'b0}};
    end else begin
      state_r      <= state_n;
      x_r          <= x_n;
      y_r          <= y_n;
      row_r        <= row_n;
      tmo_r        <= tmo_n;
      abort_pend_r <= abort_pend_n;
      fb_addr_r    <= addr_n;
      fb_rd_r      <= (state_n == S_FETCH);
      tx_pixel_r   <= pixel_n;
      tx_send_r    <= (state_n == S_WAIT_ACK) && (state_r != S_WAIT_ACK);
      busy_r       <= (state_n != S_IDLE);
      done_r       <= done_n;
      err_tmo_r    <= err_n;
      pix_r        <= pix_n;
    end
  end

  assign fb_addr   = fb_addr_r;
  assign fb_rd     = fb_rd_r;
  assign tx_pixel  = tx_pixel_r;
  assign tx_send   = tx_send_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err_tmo   = err_tmo_r;
  assign pix_count = pix_r;

endmodule
